imem_port_sched: RTL
====================

// Module: imem_port_sched
// PURPOSE
//  Owns the single port of the instruction memory and shares it between a program loader
//  (sequential write stream) and the processor's instruction fetch (random reads).
//  Holds the CPU in reset while a program loads, then hands the port to fetch.
//  Sits between the loader, the datapath's PC/ISR path and the instruction memory.
// PARAMETERS
//  MAXMEMORY  4095  highest valid word address; load or fetch beyond it is a fault
//  AW         16    address width (mem_addr, f_addr, load_count)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  ld_valid     in   1   loader presents a word on ld_data
//  ld_data      in   16  word to store at next sequential address
//  ld_last      in   1   qualifies ld_valid: this is the final program word
//  ld_ready     out  1   scheduler accepts the loader word this cycle
//  rl_req       in   1   request reload: return port to loader, restart at address 0
//  f_req        in   1   fetch request, address on f_addr
//  f_addr       in   AW  fetch word address (PC)
//  f_valid      out  1   f_rdata holds the word for the fetch accepted last cycle
//  f_rdata      out  16  registered instruction word
//  mem_addr     out  AW  memory address (combinational from state/inputs)
//  mem_wdata    out  16  memory write data
//  mem_we       out  1   memory write enable (sampled by memory on posedge)
//  mem_rdata    in   16  memory asynchronous read data
//  cpu_hold     out  1   high = keep controller/datapath in reset
//  load_count   out  AW  number of words written since last LOAD entry
//  fault        out  1   sticky: overflow or out-of-range fetch
// BEHAVIOUR
//  Reset (reset=0): state=LOAD, cpu_hold=1, ld_ready=0, f_valid=0, f_rdata=0,
//   load_count=0, fault=0, mem_we=0. Everything is cleared immediately, including mid-write.
//  States: LOAD, RUN, FAULT.
//  LOAD: ld_ready=1, cpu_hold=1, fetch ignored (f_valid stays 0).
//   ld_valid&ld_ready -> mem_we=1, mem_addr=load_count, mem_wdata=ld_data; load_count+1 next edge.
//   Accepted word with ld_last=1 -> RUN next cycle, load_count keeps its final value.
//   Accepted word with load_count==MAXMEMORY and ld_last=0 -> word written, then FAULT, fault=1.
//   No ld_valid: idle, nothing written.
//  RUN: cpu_hold=0, ld_ready=0, mem_we=0, mem_addr=f_addr.
//   f_req with f_addr<=MAXMEMORY -> next edge f_rdata<=mem_rdata, f_valid=1 for one cycle per request.
//   Back-to-back f_req gives back-to-back f_valid; latency is exactly 1 cycle.
//   f_req with f_addr>MAXMEMORY -> f_valid=1, f_rdata=16'h0000, fault=1, state stays RUN.
//   Fetch beyond load_count-1 is legal (returns memory contents); it is not a fault.
//  rl_req (any state): next edge state=LOAD, load_count=0, cpu_hold=1, f_valid=0.
//   rl_req has priority over a same-cycle f_req (that fetch is dropped) and over a
//   same-cycle loader word (the word is not written). fault is cleared by rl_req.
//  FAULT: cpu_hold=1, ld_ready=0, mem_we=0. Leave only via rl_req or reset.
//  fault is sticky except as noted above.
//  Arithmetic: load_count is an AW-bit unsigned counter that never wraps; overflow routes to FAULT.
//  mem_we is asserted only in LOAD, only combinationally with ld_valid&ld_ready, and never with rl_req.
// TESTING
//  T1 reset low 3 cycles, then high -> cpu_hold=1, ld_ready=1, load_count=0, mem_we=0.
//  T2 load 11 words (16'hB00A,16'hC900,...,16'h0FFF), ld_last on the 11th ->
//     mem[0..10] match, load_count=11, RUN one cycle later, cpu_hold=0.
//  T3 RUN: f_req at addresses 0,1,2 on consecutive cycles -> f_valid 3 consecutive cycles,
//     f_rdata=16'hB00A,16'hC900,16'hB00A.
//  T4 RUN: f_req with f_addr=16'h1000 -> f_rdata=0, f_valid=1, fault=1, state stays RUN.
//  T5 rl_req together with f_req at addr 0 -> no f_valid, LOAD, load_count=0, fault=0;
//     reload of 2 words overwrites mem[0..1].
//  T6 stream 4096 words without ld_last -> mem[4095] written, then FAULT, ld_ready=0;
//     reset low mid-stream -> immediate LOAD with load_count=0.

Source files
------------

// File: rtl/imem_port_sched.sv
// imem_port_sched: shares the single instruction-memory port between the program loader and fetch,
// holding the CPU in reset while a program streams in.
module imem_port_sched #(
   parameter int MAXMEMORY = 4095,
   parameter int AW        = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   input  logic [15:0]   ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   input  logic          rl_req,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_valid,
   output logic [15:0]   f_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          mem_we,
   input  logic [15:0]   mem_rdata,
   output logic          cpu_hold,
   output logic [AW-1:0] load_count,
   output logic          fault
);
   typedef enum logic [1:0] {LOAD, RUN, FAULT} state_t;
   localparam logic [AW-1:0] MAX_A = AW'(MAXMEMORY);
   state_t        state_q, state_d;
   logic [AW-1:0] load_count_q, load_count_d;
   logic          f_valid_q, f_valid_d, fault_q, fault_d;
   logic [15:0]   f_rdata_q, f_rdata_d;
   // reset gates the handshake so nothing is accepted or written while it is held low
   assign ld_ready   = reset && !rl_req && state_q == LOAD;
   assign mem_we     = ld_valid && ld_ready;
   assign mem_addr   = state_q == RUN ? f_addr : load_count_q;
   assign mem_wdata  = ld_data;
   assign cpu_hold   = state_q != RUN;
   assign load_count = load_count_q;
   assign f_valid    = f_valid_q;
   assign f_rdata    = f_rdata_q;
   assign fault      = fault_q;
   always_comb begin
      state_d      = state_q;
      load_count_d = load_count_q;
      f_valid_d    = 1'b0;
      f_rdata_d    = f_rdata_q;
      fault_d      = fault_q;
      if (rl_req) begin
         state_d      = LOAD;
         load_count_d = '0;
         fault_d      = 1'b0;
      end else if (mem_we) begin
         load_count_d = load_count_q + AW'(1);
         if (ld_last) state_d = RUN;
         else if (load_count_q == MAX_A) begin
            state_d = FAULT;
            fault_d = 1'b1;
         end
      end else if (state_q == RUN && f_req) begin
         f_valid_d = 1'b1;
         f_rdata_d = f_addr <= MAX_A ? mem_rdata : 16'h0000;
         fault_d   = fault_q || f_addr > MAX_A;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= LOAD;
         load_count_q <= '0;
         f_valid_q    <= 1'b0;
         f_rdata_q    <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         f_valid_q    <= f_valid_d;
         f_rdata_q    <= f_rdata_d;
         fault_q      <= fault_d;
      end
   end
endmodule
